// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: MEM-stage request/response bundle between the pipeline
// (EX/MEM and MEM/WB registers) and the data-memory access unit.
//   enable_MEM, rw_MEM, size_MEM, addr_MEM, wdata_MEM : request from EX/MEM
//   rdata, stall, done, fault                          : response to pipeline
// Modports: master = pipeline side, slave = memory access unit.
interface mem_stage_ctrl_if;
    logic        enable_MEM;
    logic        rw_MEM;
    logic [1:0]  size_MEM;
    logic [31:0] addr_MEM;
    logic [31:0] wdata_MEM;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;

    modport master (
        output enable_MEM, rw_MEM, size_MEM, addr_MEM, wdata_MEM,
        input  rdata, stall, done, fault
    );

    modport slave (
        input  enable_MEM, rw_MEM, size_MEM, addr_MEM, wdata_MEM,
        output rdata, stall, done, fault
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: multi-cycle MEM-stage data-memory access unit.
// Serialises byte/halfword/word loads and stores onto an internal byte-wide
// RAM (Mem, 2**ADDR_W bytes), one byte per cycle, big-endian, and holds the
// pipeline with a combinational stall until the access completes.
// Ports:
//   CLK  - clock, rising edge
//   CLR  - asynchronous active-high reset (RAM contents are kept)
//   bus  - mem_stage_ctrl_if.slave: request in, rdata/stall/done/fault out
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned halfword
// and word accesses with a one-cycle fault/done pulse; otherwise fault = 0.
module mem_stage_ctrl #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    mem_stage_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    logic [7:0] Mem [2**ADDR_W];

    state_e            state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic [1:0]        last_q, last_d;    // N-1 for the captured size
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [23:0]       asm_q, asm_d;      // load bytes collected so far
    logic [31:0]       rdata_q, rdata_d;

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rbyte;
    logic [1:0]        byte_sel;
    logic [7:0]        mem_wbyte;
    logic              mem_we;
    logic [1:0]        size_last;

`ifdef MEM_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic misalign;
`endif

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign mem_addr  = base_q + ADDR_W'(count_q);
    assign mem_rbyte = Mem[mem_addr];
    // Big-endian: the first transferred byte is the MSB of the sized datum.
    assign byte_sel  = last_q - count_q;
    assign mem_wbyte = wdata_q[{byte_sel, 3'b000} +: 8];
    assign mem_we    = (state_q == StAccess) && rw_q;

    always_comb begin
        size_last = 2'd3;
        unique case (bus.size_MEM)
            2'b00:   size_last = 2'd0;
            2'b01:   size_last = 2'd1;
            default: size_last = 2'd3;   // word and reserved encoding
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ((bus.size_MEM == 2'b01) && bus.addr_MEM[0]) ||
                      (bus.size_MEM[1] && (bus.addr_MEM[1:0] != 2'b00));
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
        fault_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.enable_MEM) begin
                    base_d  = bus.addr_MEM[ADDR_W-1:0];
                    wdata_d = bus.wdata_MEM;
                    rw_d    = bus.rw_MEM;
                    last_d  = size_last;
                    count_d = 2'd0;
                    asm_d   = 24'd0;
                    state_d = StAccess;
`ifdef MEM_ALIGN_CHECK_EN
                    if (misalign) begin
                        state_d = StDone;
                        fault_d = 1'b1;
                    end
`endif
                end
            end
            StAccess: begin
                count_d = count_q + 2'd1;
                if (!rw_q) begin
                    asm_d = {asm_q[15:0], mem_rbyte};
                end
                if (count_q == last_q) begin
                    state_d = StDone;
                    // asm_q was cleared at capture, so this zero-extends.
                    if (!rw_q) begin
                        rdata_d = {asm_q, mem_rbyte};
                    end
                end
            end
            StDone: begin
                // EX/MEM still holds the finished instruction: do not resample.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= StIdle;
            count_q <= 2'd0;
            last_q  <= 2'd0;
            base_q  <= '0;
            wdata_q <= 32'd0;
            rw_q    <= 1'b0;
            asm_q   <= 24'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    // RAM is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            Mem[mem_addr] <= mem_wbyte;
        end
    end

    assign bus.stall = !CLR &&
                       (((state_q == StIdle) && bus.enable_MEM) || (state_q == StAccess));
    assign bus.done  = (state_q == StDone);
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed self-checking bench for mem_stage_ctrl.
// Builds with or without MEM_ALIGN_CHECK_EN; expectations follow the macro.
module tb_mem_stage_ctrl;

    logic CLK = 1'b0;
    logic CLR = 1'b1;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl #(.ADDR_W(8)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Call at posedge+1. Holds the request until done, scrambling the
    // inputs after the capture edge; returns at posedge+1 after DONE.
    task automatic run_access(input logic rw, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output int stall_cyc, output int done_cyc,
                              output logic fault_seen, output logic [31:0] rdata_seen);
        bus.enable_MEM = 1'b1;
        bus.rw_MEM     = rw;
        bus.size_MEM   = size;
        bus.addr_MEM   = addr;
        bus.wdata_MEM  = wdata;
        stall_cyc  = 0;
        done_cyc   = 0;
        fault_seen = 1'b0;
        rdata_seen = 32'd0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            #1;
            if (bus.stall) stall_cyc++;
            if (bus.done) begin
                done_cyc   = cyc;
                fault_seen = bus.fault;
                rdata_seen = bus.rdata;
                bus.enable_MEM = 1'b0;
                @(posedge CLK);
                #1;
                break;
            end
            @(posedge CLK);
            #1;
            bus.addr_MEM  = 32'hFFFF_FF80;
            bus.wdata_MEM = 32'h5A5A_5A5A;
            bus.size_MEM  = 2'b00;
            bus.rw_MEM    = ~bus.rw_MEM;
        end
    endtask

    int          st, dn;
    logic        flt;
    logic [31:0] rd;
    int          b2b_stall, b2b_done, d1, d2;
    logic [31:0] rd2;

    initial begin
        bus.enable_MEM = 1'b0;
        bus.rw_MEM     = 1'b0;
        bus.size_MEM   = 2'b00;
        bus.addr_MEM   = 32'd0;
        bus.wdata_MEM  = 32'd0;

        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("rst_done",  {31'd0, bus.done},  32'd0);
        check_eq("rst_fault", {31'd0, bus.fault}, 32'd0);
        check_eq("rst_rdata", bus.rdata, 32'd0);
        CLR = 1'b0;
        @(posedge CLK);
        #1;

        // Word store, big-endian byte layout.
        run_access(1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, st, dn, flt, rd);
        check_eq("wst_stall", st, 5);
        check_eq("wst_done",  dn, 6);
        check_eq("wst_rdata", rd, 32'd0);
        check_eq("wst_fault", {31'd0, flt}, 32'd0);
        check_eq("wst_m10", {24'd0, dut.Mem[8'h10]}, 32'h0000_00DE);
        check_eq("wst_m11", {24'd0, dut.Mem[8'h11]}, 32'h0000_00AD);
        check_eq("wst_m12", {24'd0, dut.Mem[8'h12]}, 32'h0000_00BE);
        check_eq("wst_m13", {24'd0, dut.Mem[8'h13]}, 32'h0000_00EF);

        run_access(1'b0, 2'b00, 32'h0000_0013, 32'd0, st, dn, flt, rd);
        check_eq("bld_rdata", rd, 32'h0000_00EF);
        check_eq("bld_stall", st, 2);
        check_eq("bld_done",  dn, 3);

        run_access(1'b0, 2'b01, 32'h0000_0010, 32'd0, st, dn, flt, rd);
        check_eq("hld_rdata", rd, 32'h0000_DEAD);
        check_eq("hld_stall", st, 3);
        check_eq("hld_done",  dn, 4);
        check_eq("hld_hold",  bus.rdata, 32'h0000_DEAD);

        // Preload the wrap-around bytes through the port.
        run_access(1'b1, 2'b00, 32'h0000_00FF, 32'h0000_AB12, st, dn, flt, rd);
        run_access(1'b1, 2'b00, 32'h0000_0100, 32'h0000_CD34, st, dn, flt, rd);
        check_eq("bst_mff", {24'd0, dut.Mem[8'hFF]}, 32'h0000_0012);
        check_eq("bst_m00", {24'd0, dut.Mem[8'h00]}, 32'h0000_0034);

        run_access(1'b0, 2'b01, 32'h0000_00FF, 32'd0, st, dn, flt, rd);
`ifdef MEM_ALIGN_CHECK_EN
        check_eq("wrap_ld_fault", {31'd0, flt}, 32'd1);
        check_eq("wrap_ld_rdata", rd, 32'h0000_DEAD);
        check_eq("wrap_ld_stall", st, 1);
        check_eq("wrap_ld_done",  dn, 2);
`else
        check_eq("wrap_ld_fault", {31'd0, flt}, 32'd0);
        check_eq("wrap_ld_rdata", rd, 32'h0000_1234);
        check_eq("wrap_ld_stall", st, 3);
        check_eq("wrap_ld_done",  dn, 4);
`endif
        check_eq("fault_cleared", {31'd0, bus.fault}, 32'd0);

        run_access(1'b1, 2'b01, 32'h0000_00FF, 32'h0000_5678, st, dn, flt, rd);
`ifdef MEM_ALIGN_CHECK_EN
        check_eq("wrap_st_fault", {31'd0, flt}, 32'd1);
        check_eq("wrap_st_mff", {24'd0, dut.Mem[8'hFF]}, 32'h0000_0012);
        check_eq("wrap_st_m00", {24'd0, dut.Mem[8'h00]}, 32'h0000_0034);
`else
        check_eq("wrap_st_fault", {31'd0, flt}, 32'd0);
        check_eq("wrap_st_mff", {24'd0, dut.Mem[8'hFF]}, 32'h0000_0056);
        check_eq("wrap_st_m00", {24'd0, dut.Mem[8'h00]}, 32'h0000_0078);
`endif

        // Two word loads with enable held high throughout.
        bus.enable_MEM = 1'b1;
        bus.rw_MEM     = 1'b0;
        bus.size_MEM   = 2'b10;
        bus.addr_MEM   = 32'h0000_0010;
        b2b_stall = 0;
        b2b_done  = 0;
        d1 = 0;
        d2 = 0;
        rd2 = 32'd0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            #1;
            if (bus.stall) b2b_stall++;
            if (bus.done) begin
                b2b_done++;
                if (d1 == 0) d1 = cyc;
                else d2 = cyc;
                rd2 = bus.rdata;
            end
            @(posedge CLK);
            #1;
        end
        bus.enable_MEM = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("b2b_stall", b2b_stall, 10);
        check_eq("b2b_ndone", b2b_done, 2);
        check_eq("b2b_done1", d1, 6);
        check_eq("b2b_done2", d2, 12);
        check_eq("b2b_rdata", rd2, 32'hDEAD_BEEF);

        // Abort a word store after two bytes have been written.
        bus.enable_MEM = 1'b1;
        bus.rw_MEM     = 1'b1;
        bus.size_MEM   = 2'b10;
        bus.addr_MEM   = 32'h0000_0040;
        bus.wdata_MEM  = 32'h1122_3344;
        repeat (3) @(posedge CLK);
        #3;
        CLR = 1'b1;
        #1;
        check_eq("abort_stall", {31'd0, bus.stall}, 32'd0);
        check_eq("abort_done",  {31'd0, bus.done},  32'd0);
        check_eq("abort_rdata", bus.rdata, 32'd0);
        check_eq("abort_m40", {24'd0, dut.Mem[8'h40]}, 32'h0000_0011);
        check_eq("abort_m41", {24'd0, dut.Mem[8'h41]}, 32'h0000_0022);
        bus.enable_MEM = 1'b0;
        #2;
        CLR = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("post_rst_idle", {31'd0, bus.stall}, 32'd0);
        run_access(1'b0, 2'b00, 32'h0000_0041, 32'd0, st, dn, flt, rd);
        check_eq("post_rst_rdata", rd, 32'h0000_0022);
        check_eq("post_rst_done",  dn, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Multi-cycle data-memory access unit for the MEM stage of the ARM pipeline. It consumes the MEM-side control outputs of the EX/MEM pipeline register (`size_MEM`, `enable_MEM`, `rw_MEM`) together with the effective address and store data. It serialises byte, halfword and word accesses onto an internal 256x8 byte-wide data RAM, one byte per cycle, and asserts `stall` to freeze PC, IF/ID, ID/EX and EX/MEM until the access completes. Read data is assembled big-endian and presented to the MEM/WB register.

## Interface
Parameters:
- `ADDR_W`, 8: internal RAM address width (256 bytes); upper address bits are ignored.

Ports:
- `CLK` in 1: clock; all state updates on rising edge.
- `CLR` in 1: asynchronous, active-high reset.
- `enable_MEM` in 1: memory operation requested by the instruction in EX/MEM.
- `rw_MEM` in 1: 1 = store (write), 0 = load (read).
- `size_MEM` in 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- `addr_MEM` in 32: byte address; bits [ADDR_W-1:0] used.
- `wdata_MEM` in 32: store data; byte = [7:0], halfword = [15:0], word = [31:0].
- `rdata` out 32: zero-extended load result.
- `stall` out 1: pipeline hold request, combinational.
- `done` out 1: one-cycle pulse, access complete.
- `fault` out 1: misaligned access flag (only with `MEM_ALIGN_CHECK_EN`).

## Operation
- Reset (`CLR`=1, async): state IDLE, byte counter 0, `rdata`=0, `done`=0, `fault`=0, `stall`=0. RAM contents are not cleared. The RAM array is named `Mem` so benches can preload it hierarchically.
- The FSM has three states: IDLE, ACCESS, DONE.
- **IDLE behaviour:**
  - With `enable_MEM`=0, nothing happens and `stall`=0.
  - With `enable_MEM`=1, `stall`=1 combinationally.
  - At the next edge the block captures address, data, size and rw, sets N = 1/2/4 bytes and count = 0, and goes to ACCESS.
- **ACCESS behaviour:**
  - `stall`=1 throughout.
  - Each edge transfers byte `count` at address base+count, then increments count.
  - Big-endian ordering: byte 0 at base is the MSB of the sized datum.
    - Store: writes `Mem[base+count]` ← datum byte (N-1-count) counted from the LSB.
    - Load: shifts `Mem[base+count]` into the assembly register.
  - On the edge where count = N-1, the block goes to DONE.
- **DONE behaviour:**
  - `stall`=0 and `done`=1.
  - For loads, `rdata` is valid, zero-extended to 32 bits. For stores, `rdata` is unchanged.
  - The next edge always returns to IDLE. `enable_MEM` is ignored in DONE, because EX/MEM still holds the finished instruction during this cycle.
- `rdata` holds its value until the next load completes.
- Address wrap: base+count is computed modulo 2^ADDR_W; an access at 0xFF spans bytes 0xFF, 0x00, ...
- Input changes during ACCESS are ignored, since captured copies are used.
- `CLR` asserted mid-access aborts the access immediately. Partial store bytes already written remain in RAM.

## Timing
- An N-byte access occupies N+2 cycles from first sight of `enable_MEM` to the pipeline advancing:
  - `stall` is high for N+1 cycles (capture cycle plus N transfer cycles).
  - DONE lasts 1 cycle.
- Resulting latencies:
  - Byte: 3 cycles.
  - Halfword: 4 cycles.
  - Word: 6 cycles.
- Back-to-back memory instructions: the second request is recognised in the IDLE cycle that follows DONE. There is no overlap.
- `done` and the final `rdata` are registered; `stall` is decoded from state and inputs.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Halfword with addr[0]≠0, or word with addr[1:0]≠0, goes IDLE→DONE directly.
  - In that DONE cycle, `fault`=1 for one cycle and `done`=1.
  - No RAM write occurs and `rdata` is unchanged.
  - Stall lasts 1 cycle.
- `MEM_ALIGN_CHECK_EN` undefined:
  - No alignment check; misaligned accesses proceed byte-serially with wrap.
  - `fault` is tied to 0.

## Test plan
- Reset: `CLR`=1 mid-ACCESS of a word store → `stall`=0, `done`=0 and `rdata`=0 immediately; the FSM is in IDLE after release.
- Word store 0xDEADBEEF at 0x10 → `Mem[0x10..0x13]` = DE,AD,BE,EF; `stall` high 5 cycles; `done` pulses on cycle 6.
- Byte load from 0x13 after the above → `rdata`=0x000000EF; `stall` high 2 cycles.
- Halfword load from 0xFF with `Mem[0xFF]`=0x12 and `Mem[0x00]`=0x34, macro undefined → `rdata`=0x00001234.
- Same access with `MEM_ALIGN_CHECK_EN` → `fault`=1 and `done`=1 for one cycle; `rdata` unchanged; no writes.
- Two consecutive word loads (`enable_MEM` held high) → two separate 6-cycle sequences; `enable_MEM` is not resampled in DONE.
